program_sequencer: RTL

Program sequencer for the 9-bit processor. Owns the program counter, the 16-entry jump-target LUT, and the Start/Done handshake with the test harness. Consumes the decoder's `pc_jmp_en`/`LutPointer` plus halt and stall indications. Drives the instruction-ROM address each cycle.

---
 rtl/seq_pkg.sv | 14 +
 rtl/jump_lut.sv | 31 +++
 rtl/program_sequencer.sv | 100 ++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and sizing constants for the program sequencer and its jump-target LUT.
package seq_pkg;

    localparam int PC_W      = 10;
    localparam int LUT_DEPTH = 16;
    localparam int LUT_IDX_W = $clog2(LUT_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } seq_state_t;

endpackage

// File: rtl/jump_lut.sv
// Jump-target register file: one synchronous write port, one combinational read port,
// asynchronously cleared so every target reads zero after reset.
module jump_lut #(
    parameter int PC_W      = seq_pkg::PC_W,
    parameter int LUT_DEPTH = seq_pkg::LUT_DEPTH,
    parameter int IDX_W     = seq_pkg::LUT_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [PC_W-1:0]  wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [PC_W-1:0]  rd_data
);

    logic [PC_W-1:0] mem [LUT_DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/program_sequencer.sv
// Program sequencer: owns the PC, the jump-target LUT and the Start/Done handshake.
// All outputs are registers or decodes of the state register (no input-to-output paths).
module program_sequencer #(
    parameter int PC_W      = seq_pkg::PC_W,
    parameter int LUT_DEPTH = seq_pkg::LUT_DEPTH,
    parameter int CNT_W     = 16
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          Start,
    input  logic [PC_W-1:0]               StartAddr,
    input  logic                          pc_jmp_en,
    input  logic [seq_pkg::LUT_IDX_W-1:0] LutPointer,
    input  logic                          halt_instr,
    input  logic                          stall,
    input  logic                          lut_wr_en,
    input  logic [seq_pkg::LUT_IDX_W-1:0] lut_wr_idx,
    input  logic [PC_W-1:0]               lut_wr_data,
    output logic [PC_W-1:0]               PC,
    output logic                          fetch_en,
    output logic                          Done,
    output logic [CNT_W-1:0]              cycle_count
);

    import seq_pkg::*;

    seq_state_t       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  lut_target;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lut_wr_gated;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    // Jump targets are frozen while a program runs, so a jump never races a write.
    assign lut_wr_gated = lut_wr_en && (state_q != RUN);

    jump_lut #(
        .PC_W      (PC_W),
        .LUT_DEPTH (LUT_DEPTH),
        .IDX_W     (LUT_IDX_W)
    ) u_jump_lut (
        .clk     (Clk),
        .rst     (Reset),
        .wr_en   (lut_wr_gated),
        .wr_idx  (lut_wr_idx),
        .wr_data (lut_wr_data),
        .rd_idx  (LutPointer),
        .rd_data (lut_target)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, HALTED: begin
                if (Start) begin
                    state_d = RUN;
                    pc_d    = StartAddr;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = sat_inc(cnt_q);
                // Halt beats stall beats jump; a stalled jump is dropped, the decoder repeats it.
                if (halt_instr) begin
                    state_d = HALTED;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (pc_jmp_en) begin
                    pc_d = lut_target;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign PC          = pc_q;
    assign fetch_en    = (state_q == RUN);
    assign Done        = (state_q == HALTED);
    assign cycle_count = cnt_q;

endmodule
